// File: rtl/freefall_scheduler.sv
// Time-shares one registered free-fall datapath across N_OBJ objects.
// Holds per-object height/velocity, clamps results at the floor and launches jumps.
module freefall_scheduler #(
  parameter int unsigned  N_OBJ   = 4,
  parameter logic [8:0]   GROUND  = 9'd16,
  parameter logic [8:0]   JUMP_V  = 9'd60,
  parameter logic [8:0]   Y_RESET = 9'd200,
  localparam int unsigned IDX_W   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic [N_OBJ-1:0] obj_en,
  input  logic [N_OBJ-1:0] jump,
  output logic [8:0]       dp_y_init,
  output logic [8:0]       dp_v_init,
  input  logic [8:0]       dp_y,
  input  logic [8:0]       dp_v,
  input  logic [IDX_W-1:0] rd_sel,
  output logic [8:0]       rd_y,
  output logic [8:0]       rd_v,
  output logic             rd_grounded,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_overrun
);

  localparam int unsigned DW = 9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic [DW-1:0]    y_q [N_OBJ];
  logic [DW-1:0]    y_d [N_OBJ];
  logic [DW-1:0]    v_q [N_OBJ];
  logic [DW-1:0]    v_d [N_OBJ];
  logic [N_OBJ-1:0] gnd_q, gnd_d;
  logic [N_OBJ-1:0] jp_q, jp_d;

  logic             first_vld, next_vld;
  logic [IDX_W-1:0] first_idx, next_idx;

  // Lowest enabled object overall, and lowest enabled object above idx_q.
  always_comb begin
    first_vld = 1'b0;
    first_idx = '0;
    next_vld  = 1'b0;
    next_idx  = '0;
    for (int i = int'(N_OBJ) - 1; i >= 0; i--) begin
      if (obj_en[i]) begin
        first_vld = 1'b1;
        first_idx = IDX_W'(i);
        if (i > int'(idx_q)) begin
          next_vld = 1'b1;
          next_idx = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    ovr_d     = ovr_q;
    y_d       = y_q;
    v_d       = v_q;
    gnd_d     = gnd_q;
    jp_d      = jp_q;
    dp_y_init = '0;
    dp_v_init = '0;

    // Jumps only arm on the ground, and never while that object is being written back.
    for (int unsigned i = 0; i < N_OBJ; i++) begin
      if (jump[i] && gnd_q[i] &&
          !(state_q == S_CAPTURE && idx_q == IDX_W'(i))) begin
        jp_d[i] = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (frame_tick || pend_q) begin
          pend_d = 1'b0;
          if (first_vld) begin
            idx_d   = first_idx;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        dp_y_init = y_q[idx_q];
        dp_v_init = jp_q[idx_q] ? JUMP_V : v_q[idx_q];
        state_d   = S_CAPTURE;
      end
      S_CAPTURE: begin
        jp_d[idx_q] = 1'b0;
        if (dp_y[DW-1] || dp_y < GROUND) begin
          y_d[idx_q]   = GROUND;
          v_d[idx_q]   = '0;
          gnd_d[idx_q] = 1'b1;
        end else begin
          y_d[idx_q]   = dp_y;
          v_d[idx_q]   = dp_v;
          gnd_d[idx_q] = 1'b0;
        end
        if (next_vld) begin
          idx_d   = next_idx;
          state_d = S_ISSUE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A tick is queued once; a second queued tick is flagged and dropped.
    if (frame_tick) begin
      if (pend_q) begin
        ovr_d  = 1'b1;
        pend_d = 1'b1;
      end else if (state_q != S_IDLE) begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      gnd_q   <= '0;
      jp_q    <= '0;
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        y_q[i] <= Y_RESET;
        v_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      gnd_q   <= gnd_d;
      jp_q    <= jp_d;
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        y_q[i] <= y_d[i];
        v_q[i] <= v_d[i];
      end
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign frame_done    = (state_q == S_DONE);
  assign frame_overrun = ovr_q;
  assign rd_y          = y_q[rd_sel];
  assign rd_v          = v_q[rd_sel];
  assign rd_grounded   = gnd_q[rd_sel];

endmodule

// File: tb/tb_freefall_scheduler.sv
// Scoreboarded bench: a frame-level object model predicts datapath issues and
// per-frame results; a monitor compares them whenever the DUT presents them.
module tb_freefall_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_tick;
  logic [N-1:0] obj_en;
  logic [N-1:0] jump;
  logic [8:0]   dp_y_init, dp_v_init;
  logic [8:0]   dp_y = '0;
  logic [8:0]   dp_v = '0;
  logic [1:0]   rd_sel = '0;
  logic [8:0]   rd_y, rd_v;
  logic         rd_grounded, busy, frame_done, frame_overrun;

  freefall_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .obj_en       (obj_en),
    .jump         (jump),
    .dp_y_init    (dp_y_init),
    .dp_v_init    (dp_v_init),
    .dp_y         (dp_y),
    .dp_v         (dp_v),
    .rd_sel       (rd_sel),
    .rd_y         (rd_y),
    .rd_v         (rd_v),
    .rd_grounded  (rd_grounded),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment physics: gravity 14 per step, height moves by the mean velocity.
  function automatic logic [17:0] phys(input logic [8:0] y, input logic [8:0] v);
    int vi, vn, yn;
    vi = int'($signed(v));
    vn = vi - 14;
    yn = int'(y) + ((vi + vn) >>> 1);
    return {9'(yn), 9'(vn)};
  endfunction

  always @(posedge clk) begin
    {dp_y, dp_v} <= phys(dp_y_init, dp_v_init);
  end

  typedef struct packed {
    int          done_cyc;
    logic        ovr;
    logic [35:0] ys;
    logic [35:0] vs;
    logic [3:0]  gs;
  } exp_t;

  typedef struct packed {
    logic [8:0] y;
    logic [8:0] v;
  } iss_t;

  exp_t fq[$];
  exp_t sq[$];
  iss_t iq[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input bit ok, input string nm, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model of the objects, advanced one whole frame at a time.
  logic [8:0] m_y [N];
  logic [8:0] m_v [N];
  logic [N-1:0] m_g, m_jp;
  logic         m_ovr;

  function automatic exp_t snapshot(input int done_cyc);
    exp_t e;
    e.done_cyc = done_cyc;
    e.ovr      = m_ovr;
    e.gs       = m_g;
    for (int i = 0; i < N; i++) begin
      e.ys[i*9 +: 9] = m_y[i];
      e.vs[i*9 +: 9] = m_v[i];
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_y[i] = 9'd200;
      m_v[i] = 9'd0;
    end
    m_g   = '0;
    m_jp  = '0;
    m_ovr = 1'b0;
  endtask

  task automatic model_jump(input logic [N-1:0] j);
    m_jp = m_jp | (j & m_g);
  endtask

  task automatic model_frame(input logic [N-1:0] en, input int start_cyc);
    int n;
    iss_t it;
    logic [17:0] r;
    n = 0;
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        n++;
        it.y = m_y[i];
        it.v = m_jp[i] ? 9'd60 : m_v[i];
        iq.push_back(it);
        r = phys(it.y, it.v);
        if (r[17] || r[17:9] < 9'd16) begin
          m_y[i] = 9'd16;
          m_v[i] = 9'd0;
          m_g[i] = 1'b1;
        end else begin
          m_y[i] = r[17:9];
          m_v[i] = r[8:0];
          m_g[i] = 1'b0;
        end
        m_jp[i] = 1'b0;
      end
    end
    fq.push_back(snapshot(start_cyc + 2*n + 1));
  endtask

  task automatic sweep(input exp_t e);
    for (int i = 0; i < N; i++) begin
      rd_sel = 2'(i);
      #1;
      check(rd_y == e.ys[i*9 +: 9], $sformatf("rd_y[%0d]", i), int'(rd_y), int'(e.ys[i*9 +: 9]));
      check(rd_v == e.vs[i*9 +: 9], $sformatf("rd_v[%0d]", i), int'(rd_v), int'(e.vs[i*9 +: 9]));
      check(rd_grounded == e.gs[i], $sformatf("rd_grounded[%0d]", i), int'(rd_grounded), int'(e.gs[i]));
    end
  endtask

  // Monitor: datapath issues, frame completions and post-reset state snapshots.
  always @(negedge clk) begin : mon
    iss_t it;
    exp_t e;
    if (!rst) begin
      if (dp_y_init != '0 || dp_v_init != '0) begin
        if (iq.size() == 0) check(1'b0, "unexpected_issue", int'(dp_y_init), 0);
        else begin
          it = iq.pop_front();
          check(dp_y_init == it.y, "issue_y", int'(dp_y_init), int'(it.y));
          check(dp_v_init == it.v, "issue_v", int'(dp_v_init), int'(it.v));
        end
      end
      if (frame_done) begin
        if (fq.size() == 0) check(1'b0, "unexpected_done", cyc, 0);
        else begin
          e = fq.pop_front();
          check(cyc == e.done_cyc, "done_cycle", cyc, e.done_cyc);
          check(busy == 1'b1, "busy_at_done", int'(busy), 1);
          check(frame_overrun == e.ovr, "overrun_at_done", int'(frame_overrun), int'(e.ovr));
          sweep(e);
        end
      end else if (sq.size() != 0) begin
        e = sq.pop_front();
        check(busy == 1'b0, "busy_idle", int'(busy), 0);
        check(frame_overrun == e.ovr, "overrun_idle", int'(frame_overrun), int'(e.ovr));
        sweep(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [N-1:0] en, input logic [N-1:0] j);
    int n;
    if (j != '0) begin
      jump = j;
      model_jump(j);
      step();
      jump = '0;
    end
    n = $countones(en);
    obj_en     = en;
    frame_tick = 1'b1;
    model_frame(en, cyc);
    step();
    frame_tick = 1'b0;
    repeat (2*n + 2) step();
  endtask

  initial begin : drv
    int t;
    rst        = 1'b1;
    frame_tick = 1'b0;
    obj_en     = '0;
    jump       = '0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    check(dp_y_init == 9'd0, "reset_dp_y_init", int'(dp_y_init), 0);
    check(dp_v_init == 9'd0, "reset_dp_v_init", int'(dp_v_init), 0);
    check(frame_done == 1'b0, "reset_frame_done", int'(frame_done), 0);
    sq.push_back(snapshot(0));
    step();
    step();

    // Single object from reset: (200,0) -> (193,-14), then fall to the floor.
    run_frame(4'b0001, '0);
    for (int k = 0; k < 8; k++) run_frame(4'b0001, '0);

    // Jump on airborne object 1 is ignored; jump on grounded object 0 launches.
    run_frame(4'b0011, 4'b0010);
    run_frame(4'b0001, 4'b0001);
    for (int k = 0; k < 12; k++) run_frame(4'b0001, '0);

    // Jump landing in the same cycle as object 0's write-back is dropped.
    obj_en     = 4'b0001;
    frame_tick = 1'b1;
    t          = cyc;
    model_frame(4'b0001, t);
    step();
    frame_tick = 1'b0;
    step();
    jump = 4'b0001;
    step();
    jump = '0;
    repeat (3) step();
    run_frame(4'b0001, '0);

    // Object 2 disabled while object 0 is in flight: skipped this frame.
    obj_en     = 4'b1111;
    frame_tick = 1'b1;
    t          = cyc;
    model_frame(4'b1011, t);
    step();
    frame_tick = 1'b0;
    obj_en     = 4'b1011;
    repeat (8) step();

    // No objects enabled: DONE right after IDLE.
    run_frame(4'b0000, '0);

    // Ticks at +0, +3, +5: second frame follows back-to-back, overrun sticks.
    obj_en     = 4'b1111;
    frame_tick = 1'b1;
    t          = cyc;
    m_ovr      = 1'b1;
    model_frame(4'b1111, t);
    model_frame(4'b1111, t + 10);
    step();
    frame_tick = 1'b0;
    step();
    step();
    check(busy == 1'b1, "busy_mid_frame", int'(busy), 1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (17) step();

    // Randomized frames with occasional jump bursts.
    for (int k = 0; k < 40; k++) begin
      run_frame(4'($urandom_range(0, 15)),
                ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
    end

    // Reset during CAPTURE of object 2 abandons the frame.
    obj_en     = 4'b1111;
    frame_tick = 1'b1;
    t          = cyc;
    model_frame(4'b1111, t);
    step();
    frame_tick = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    check(busy == 1'b0, "rst_busy", int'(busy), 0);
    check(frame_done == 1'b0, "rst_frame_done", int'(frame_done), 0);
    check(frame_overrun == 1'b0, "rst_overrun", int'(frame_overrun), 0);
    check(dp_v_init == 9'd0, "rst_dp_v_init", int'(dp_v_init), 0);
    iq.delete();
    fq.delete();
    model_reset();
    step();
    step();
    rst = 1'b0;
    sq.push_back(snapshot(0));
    repeat (10) step();

    check(fq.size() == 0, "frames_outstanding", fq.size(), 0);
    check(iq.size() == 0, "issues_outstanding", iq.size(), 0);
    check(sq.size() == 0, "snapshots_outstanding", sq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
